// File: rtl/m14k_wsram_update_ctl_pkg.sv
// Shared definitions for the way-select (WS) RAM update controller.
//   - request op codes and controller state encodings
//   - WS word layout: [5:0] pairwise LRU bits, [9:6] dirty bits (bit 6+w = way w)
//   - helpers that map a way pair to its LRU bit and decide relative age
package m14k_wsram_update_ctl_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP      = 2'b00,
        OP_TOUCH       = 2'b01,
        OP_TOUCH_DIRTY = 2'b10,
        OP_CLEAN       = 2'b11
    } ws_op_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_IDLE = 2'b01,
        ST_RMW  = 2'b10
    } ws_state_e;

    localparam int MAX_WAYS   = 4;
    localparam int LRU_BITS   = 6;
    localparam int DIRTY_BASE = 6;
    localparam int WS_BITS    = LRU_BITS + MAX_WAYS;

    // LRU bit holding the relative age of ways a and b (order-independent).
    // Pairs: (0,1)->2 (0,2)->1 (0,3)->0 (1,2)->5 (1,3)->3 (2,3)->4.
    function automatic int pair_bit(input int a, input int b);
        int lo;
        int hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (lo == 0 && hi == 1) return 2;
        if (lo == 0 && hi == 2) return 1;
        if (lo == 0 && hi == 3) return 0;
        if (lo == 1 && hi == 2) return 5;
        if (lo == 1 && hi == 3) return 3;
        return 4;
    endfunction

    // True when way w is older (less recently used) than way v.
    // A set pair bit means the lower-numbered way of the pair is the more recent one.
    function automatic logic way_older(input logic [LRU_BITS-1:0] lru, input int w, input int v);
        logic b;
        b = lru[pair_bit(w, v)];
        return (w < v) ? ~b : b;
    endfunction

endpackage

// File: rtl/m14k_wsram_update_ctl_lru_calc.sv
// Combinational LRU/dirty evaluation for one WS RAM word.
// Ports:
//   lru, dirty        current WS word fields (as read from the RAM)
//   way, op           way operated on and requested operation
//   victim            lowest-numbered way older than every other valid way
//   victim_dirty      dirty bit of victim
//   dirty_vec         dirty bits of valid ways (unused ways forced to 0)
//   wr_en             a write-back is required
//   wr_mask, wr_data  bit mask and new word for the write-back
module m14k_wsram_update_ctl_lru_calc
    import m14k_wsram_update_ctl_pkg::*;
#(
    parameter int ASSOC = 4
) (
    input  logic [LRU_BITS-1:0] lru,
    input  logic [MAX_WAYS-1:0] dirty,
    input  logic [1:0]          way,
    input  ws_op_e              op,
    output logic [1:0]          victim,
    output logic                victim_dirty,
    output logic [MAX_WAYS-1:0] dirty_vec,
    output logic                wr_en,
    output logic [WS_BITS-1:0]  wr_mask,
    output logic [WS_BITS-1:0]  wr_data
);

    logic [MAX_WAYS-1:0] oldest;
    logic [MAX_WAYS-1:0] valid_ways;

    // Per way: is it older than every other valid way?
    for (genvar gi = 0; gi < MAX_WAYS; gi++) begin : g_way
        logic is_oldest;

        always_comb begin
            is_oldest = (gi < ASSOC);
            for (int v = 0; v < MAX_WAYS; v++) begin
                if (v != gi && v < ASSOC && !way_older(lru, gi, v)) begin
                    is_oldest = 1'b0;
                end
            end
        end

        assign oldest[gi]     = is_oldest;
        assign valid_ways[gi] = (gi < ASSOC);
    end

    // Lowest-numbered candidate wins; a corrupt matrix with no candidate falls back to way 0.
    always_comb begin
        victim = 2'd0;
        for (int w = MAX_WAYS - 1; w >= 0; w--) begin
            if (oldest[w]) begin
                victim = 2'(w);
            end
        end
    end

    assign dirty_vec    = dirty & valid_ways;
    assign victim_dirty = dirty_vec[victim];

    // Write-back word. Bits outside the mask carry the old value so the word is
    // self-consistent, but only masked bits are actually written.
    always_comb begin
        wr_en   = 1'b0;
        wr_mask = '0;
        wr_data = {dirty, lru};
        // Out-of-range way degrades to a lookup: no write.
        if (op != OP_LOOKUP && int'(way) < ASSOC) begin
            wr_en = 1'b1;
            if (op == OP_CLEAN) begin
                wr_mask[DIRTY_BASE + int'(way)] = 1'b1;
                wr_data[DIRTY_BASE + int'(way)] = 1'b0;
            end else begin
                for (int v = 0; v < MAX_WAYS; v++) begin
                    if (v < ASSOC && v != int'(way)) begin
                        wr_mask[pair_bit(int'(way), v)] = 1'b1;
                        wr_data[pair_bit(int'(way), v)] = (int'(way) < v);
                    end
                end
                if (op == OP_TOUCH_DIRTY) begin
                    wr_mask[DIRTY_BASE + int'(way)] = 1'b1;
                    wr_data[DIRTY_BASE + int'(way)] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/m14k_wsram_update_ctl.sv
// Read-modify-write controller for the cache way-select (WS) RAM; sole WS RAM master.
// After reset it clears every WS line, then serves one request per two cycles:
// read the line, return victim/dirty state, and write back updated LRU/dirty bits.
// Ports:
//   clk, greset                 clock, synchronous active-high reset
//   req_valid/req_ready         request handshake; req_idx/req_way/req_op request fields
//   rsp_valid                   one-cycle response strobe with rsp_victim,
//                               rsp_victim_dirty, rsp_dirty_vec (pre-update state)
//   init_done                   clear sweep complete (sticky until reset)
//   ws_line_idx, ws_rd_str      WS RAM index and read strobe (data valid next cycle)
//   ws_wr_str, ws_wr_mask,
//   ws_wr_data                  WS RAM write strobe, per-bit mask and data
//   ws_rd_data                  WS RAM read data
module m14k_wsram_update_ctl
    import m14k_wsram_update_ctl_pkg::*;
#(
    parameter int ASSOC    = 4,
    parameter int WS_DEPTH = 8,
    parameter int WS_WIDTH = 10
) (
    input  logic                clk,
    input  logic                greset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [WS_DEPTH-1:0] req_idx,
    input  logic [1:0]          req_way,
    input  logic [1:0]          req_op,
    output logic                rsp_valid,
    output logic [1:0]          rsp_victim,
    output logic                rsp_victim_dirty,
    output logic [3:0]          rsp_dirty_vec,
    output logic                init_done,
    output logic [WS_DEPTH-1:0] ws_line_idx,
    output logic                ws_rd_str,
    output logic                ws_wr_str,
    output logic [WS_WIDTH-1:0] ws_wr_mask,
    output logic [WS_WIDTH-1:0] ws_wr_data,
    input  logic [WS_WIDTH-1:0] ws_rd_data
);

    ws_state_e           state_reg, state_next;
    logic [WS_DEPTH-1:0] init_cnt_reg, init_cnt_next;
    logic                init_done_reg, init_done_next;
    logic [WS_DEPTH-1:0] req_idx_reg, req_idx_next;
    logic [1:0]          req_way_reg, req_way_next;
    ws_op_e              req_op_reg, req_op_next;

    logic [1:0]          calc_victim;
    logic                calc_victim_dirty;
    logic [MAX_WAYS-1:0] calc_dirty_vec;
    logic                calc_wr_en;
    logic [WS_BITS-1:0]  calc_wr_mask;
    logic [WS_BITS-1:0]  calc_wr_data;

    m14k_wsram_update_ctl_lru_calc #(
        .ASSOC(ASSOC)
    ) u_lru_calc (
        .lru         (ws_rd_data[LRU_BITS-1:0]),
        .dirty       (ws_rd_data[DIRTY_BASE +: MAX_WAYS]),
        .way         (req_way_reg),
        .op          (req_op_reg),
        .victim      (calc_victim),
        .victim_dirty(calc_victim_dirty),
        .dirty_vec   (calc_dirty_vec),
        .wr_en       (calc_wr_en),
        .wr_mask     (calc_wr_mask),
        .wr_data     (calc_wr_data)
    );

    always_ff @(posedge clk) begin
        if (greset) begin
            state_reg     <= ST_INIT;
            init_cnt_reg  <= '0;
            init_done_reg <= 1'b0;
            req_idx_reg   <= '0;
            req_way_reg   <= 2'd0;
            req_op_reg    <= OP_LOOKUP;
        end else begin
            state_reg     <= state_next;
            init_cnt_reg  <= init_cnt_next;
            init_done_reg <= init_done_next;
            req_idx_reg   <= req_idx_next;
            req_way_reg   <= req_way_next;
            req_op_reg    <= req_op_next;
        end
    end

    assign init_done = init_done_reg;

    always_comb begin
        state_next       = state_reg;
        init_cnt_next    = init_cnt_reg;
        init_done_next   = init_done_reg;
        req_idx_next     = req_idx_reg;
        req_way_next     = req_way_reg;
        req_op_next      = req_op_reg;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        rsp_victim       = 2'd0;
        rsp_victim_dirty = 1'b0;
        rsp_dirty_vec    = 4'd0;
        ws_line_idx      = '0;
        ws_rd_str        = 1'b0;
        ws_wr_str        = 1'b0;
        ws_wr_mask       = '0;
        ws_wr_data       = '0;

        // Outputs are held quiet while reset is asserted so a request caught
        // mid read-modify-write is dropped without a write or a response.
        if (!greset) begin
            case (state_reg)
                ST_INIT: begin
                    ws_wr_str     = 1'b1;
                    ws_wr_mask    = '1;
                    ws_line_idx   = init_cnt_reg;
                    init_cnt_next = init_cnt_reg + 1'b1;
                    if (init_cnt_reg == {WS_DEPTH{1'b1}}) begin
                        init_done_next = 1'b1;
                        state_next     = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        ws_rd_str    = 1'b1;
                        ws_line_idx  = req_idx;
                        req_idx_next = req_idx;
                        req_way_next = req_way;
                        req_op_next  = ws_op_e'(req_op);
                        state_next   = ST_RMW;
                    end
                end
                ST_RMW: begin
                    // Read data arrives this cycle; the write lands before any
                    // later read can be issued, so no bypass path is needed.
                    rsp_valid        = 1'b1;
                    rsp_victim       = calc_victim;
                    rsp_victim_dirty = calc_victim_dirty;
                    rsp_dirty_vec    = calc_dirty_vec;
                    ws_line_idx      = req_idx_reg;
                    if (calc_wr_en) begin
                        ws_wr_str  = 1'b1;
                        ws_wr_mask = WS_WIDTH'(calc_wr_mask);
                        ws_wr_data = WS_WIDTH'(calc_wr_data);
                    end
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m14k_wsram_update_ctl.sv
// Two controller instances (ASSOC=4 and ASSOC=2, WS_DEPTH=4), each with a
// behavioural WS RAM. Stimulus pushes expected responses/writes into queues;
// a negedge monitor pops and compares whenever a DUT strobes.
module tb_m14k_wsram_update_ctl;

    localparam int WS_DEPTH = 4;
    localparam int WS_WIDTH = 10;
    localparam int NI       = 2;

    localparam logic [1:0] LOOKUP = 2'b00;
    localparam logic [1:0] TOUCH  = 2'b01;
    localparam logic [1:0] TDIRTY = 2'b10;
    localparam logic [1:0] CLEAN  = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                greset           [NI];
    logic                req_valid        [NI];
    logic                req_ready        [NI];
    logic [WS_DEPTH-1:0] req_idx          [NI];
    logic [1:0]          req_way          [NI];
    logic [1:0]          req_op           [NI];
    logic                rsp_valid        [NI];
    logic [1:0]          rsp_victim       [NI];
    logic                rsp_victim_dirty [NI];
    logic [3:0]          rsp_dirty_vec    [NI];
    logic                init_done        [NI];
    logic [WS_DEPTH-1:0] ws_line_idx      [NI];
    logic                ws_rd_str        [NI];
    logic                ws_wr_str        [NI];
    logic [WS_WIDTH-1:0] ws_wr_mask       [NI];
    logic [WS_WIDTH-1:0] ws_wr_data       [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int A = (gi == 0) ? 4 : 2;
        logic [WS_WIDTH-1:0] mem [16];
        logic [WS_WIDTH-1:0] rd_q;

        m14k_wsram_update_ctl #(
            .ASSOC   (A),
            .WS_DEPTH(WS_DEPTH),
            .WS_WIDTH(WS_WIDTH)
        ) u_dut (
            .clk             (clk),
            .greset          (greset[gi]),
            .req_valid       (req_valid[gi]),
            .req_ready       (req_ready[gi]),
            .req_idx         (req_idx[gi]),
            .req_way         (req_way[gi]),
            .req_op          (req_op[gi]),
            .rsp_valid       (rsp_valid[gi]),
            .rsp_victim      (rsp_victim[gi]),
            .rsp_victim_dirty(rsp_victim_dirty[gi]),
            .rsp_dirty_vec   (rsp_dirty_vec[gi]),
            .init_done       (init_done[gi]),
            .ws_line_idx     (ws_line_idx[gi]),
            .ws_rd_str       (ws_rd_str[gi]),
            .ws_wr_str       (ws_wr_str[gi]),
            .ws_wr_mask      (ws_wr_mask[gi]),
            .ws_wr_data      (ws_wr_data[gi]),
            .ws_rd_data      (rd_q)
        );

        // Garbage contents so the clear sweep is observable.
        initial begin
            for (int k = 0; k < 16; k++) mem[k] = 10'h3A5 ^ 10'(k);
        end

        always @(posedge clk) begin
            if (ws_rd_str[gi]) rd_q <= mem[ws_line_idx[gi]];
            if (ws_wr_str[gi])
                mem[ws_line_idx[gi]] = (mem[ws_line_idx[gi]] & ~ws_wr_mask[gi]) |
                                       (ws_wr_data[gi] & ws_wr_mask[gi]);
        end
    end

    typedef struct {
        int         inst;
        logic [1:0] victim;
        logic       vd;
        logic [3:0] dvec;
    } rsp_t;

    typedef struct {
        int                  inst;
        logic [WS_DEPTH-1:0] idx;
        logic [WS_WIDTH-1:0] mask;
        logic [WS_WIDTH-1:0] data;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   init_exp [NI];

    // Monitor / scoreboard
    always @(negedge clk) begin
        rsp_t r;
        wr_t  w;
        for (int i = 0; i < NI; i++) begin
            if (greset[i]) begin
                init_exp[i] = 0;
                checks++;
                if (req_ready[i] || rsp_valid[i] || ws_wr_str[i] || ws_rd_str[i]) begin
                    failures++;
                    $display("FAIL reset_quiet inst%0d: ready=%b rsp=%b wr=%b rd=%b required all 0",
                             i, req_ready[i], rsp_valid[i], ws_wr_str[i], ws_rd_str[i]);
                end
            end else begin
                if (ws_wr_str[i] && !init_done[i]) begin
                    checks++;
                    if (init_exp[i] > 15 || ws_line_idx[i] != 4'(init_exp[i]) ||
                        ws_wr_mask[i] != 10'h3FF || ws_wr_data[i] != 10'h000) begin
                        failures++;
                        $display("FAIL init_clear inst%0d: idx=%0d mask=%h data=%h required idx=%0d mask=3ff data=000",
                                 i, ws_line_idx[i], ws_wr_mask[i], ws_wr_data[i], init_exp[i]);
                    end
                    init_exp[i]++;
                end else if (ws_wr_str[i]) begin
                    checks++;
                    if (wr_q.size() == 0 || wr_q[0].inst != i) begin
                        failures++;
                        $display("FAIL unexpected_write inst%0d: idx=%0d mask=%h data=%h required no write",
                                 i, ws_line_idx[i], ws_wr_mask[i], ws_wr_data[i]);
                    end else begin
                        w = wr_q.pop_front();
                        if (ws_line_idx[i] != w.idx || ws_wr_mask[i] != w.mask || ws_wr_data[i] != w.data) begin
                            failures++;
                            $display("FAIL write inst%0d: idx=%0d mask=%h data=%h required idx=%0d mask=%h data=%h",
                                     i, ws_line_idx[i], ws_wr_mask[i], ws_wr_data[i], w.idx, w.mask, w.data);
                        end else begin
                            $display("write inst%0d idx=%0d mask=%h data=%h ok", i, w.idx, w.mask, w.data);
                        end
                    end
                end
                if (rsp_valid[i]) begin
                    checks++;
                    if (rsp_q.size() == 0 || rsp_q[0].inst != i) begin
                        failures++;
                        $display("FAIL unexpected_rsp inst%0d: victim=%0d required no response", i, rsp_victim[i]);
                    end else begin
                        r = rsp_q.pop_front();
                        if (rsp_victim[i] != r.victim || rsp_victim_dirty[i] != r.vd || rsp_dirty_vec[i] != r.dvec) begin
                            failures++;
                            $display("FAIL response inst%0d: victim=%0d vdirty=%b dvec=%b required victim=%0d vdirty=%b dvec=%b",
                                     i, rsp_victim[i], rsp_victim_dirty[i], rsp_dirty_vec[i], r.victim, r.vd, r.dvec);
                        end else begin
                            $display("rsp inst%0d victim=%0d vdirty=%b dvec=%b ok", i, r.victim, r.vd, r.dvec);
                        end
                    end
                end
            end
        end
    end

    // Called right after reset is released: cycle 1 clears idx 0, init_done shows on cycle 17.
    task automatic wait_init(input int i);
        int n = 1;
        while (!init_done[i] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 17) begin
            failures++;
            $display("FAIL init_done_cycle inst%0d: cycle=%0d required 17", i, n);
        end
        checks++;
        if (req_ready[i] !== 1'b1 || init_exp[i] != 16) begin
            failures++;
            $display("FAIL post_init inst%0d: ready=%b clears=%0d required ready=1 clears=16",
                     i, req_ready[i], init_exp[i]);
        end
        $display("init inst%0d done at cycle %0d", i, n);
    endtask

    task automatic issue(input int i, input logic [1:0] op, input logic [3:0] idx, input logic [1:0] way,
                         input bit wr, input logic [9:0] mask, input logic [9:0] data,
                         input logic [1:0] vic, input logic vd, input logic [3:0] dvec);
        int   k = 0;
        rsp_t r;
        wr_t  w;
        r.inst = i; r.victim = vic; r.vd = vd; r.dvec = dvec;
        rsp_q.push_back(r);
        if (wr) begin
            w.inst = i; w.idx = idx; w.mask = mask; w.data = data;
            wr_q.push_back(w);
        end
        req_valid[i] = 1'b1;
        req_op[i]    = op;
        req_idx[i]   = idx;
        req_way[i]   = way;
        while (!req_ready[i] && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (!req_ready[i]) begin
            failures++;
            $display("FAIL ready_timeout inst%0d: ready=%b required 1 within 20 cycles", i, req_ready[i]);
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            greset[i]    = 1'b1;
            req_valid[i] = 1'b0;
            req_idx[i]   = '0;
            req_way[i]   = 2'd0;
            req_op[i]    = LOOKUP;
            init_exp[i]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        greset[0] = 1'b0;
        greset[1] = 1'b0;
        fork
            wait_init(0);
            wait_init(1);
        join

        // ASSOC=4, idx 5: inst op idx way | wr mask data | victim vdirty dvec
        issue(0, TOUCH,  5, 0, 1, 10'h007, 10'h007, 0, 0, 4'b0000);
        issue(0, TOUCH,  5, 1, 1, 10'h02C, 10'h02B, 1, 0, 4'b0000);
        issue(0, TOUCH,  5, 2, 1, 10'h032, 10'h019, 2, 0, 4'b0000);
        issue(0, TOUCH,  5, 3, 1, 10'h019, 10'h000, 3, 0, 4'b0000);
        issue(0, LOOKUP, 5, 0, 0, 10'h000, 10'h000, 0, 0, 4'b0000);
        issue(0, TDIRTY, 5, 2, 1, 10'h132, 10'h110, 0, 0, 4'b0000);
        issue(0, TOUCH,  5, 0, 1, 10'h007, 10'h117, 0, 0, 4'b0100);
        issue(0, TOUCH,  5, 1, 1, 10'h02C, 10'h13B, 1, 0, 4'b0100);
        issue(0, TOUCH,  5, 3, 1, 10'h019, 10'h122, 3, 0, 4'b0100);
        issue(0, LOOKUP, 5, 1, 0, 10'h000, 10'h000, 2, 1, 4'b0100);
        issue(0, CLEAN,  5, 2, 1, 10'h100, 10'h022, 2, 1, 4'b0100);
        issue(0, LOOKUP, 5, 0, 0, 10'h000, 10'h000, 2, 0, 4'b0000);
        issue(0, LOOKUP, 6, 0, 0, 10'h000, 10'h000, 0, 0, 4'b0000);

        // ASSOC=2, idx 3
        issue(1, TOUCH,  3, 0, 1, 10'h004, 10'h004, 0, 0, 4'b0000);
        issue(1, TOUCH,  3, 1, 1, 10'h004, 10'h000, 1, 0, 4'b0000);
        issue(1, LOOKUP, 3, 0, 0, 10'h000, 10'h000, 0, 0, 4'b0000);
        issue(1, TDIRTY, 3, 3, 0, 10'h000, 10'h000, 0, 0, 4'b0000);
        issue(1, TDIRTY, 3, 1, 1, 10'h084, 10'h080, 0, 0, 4'b0000);
        issue(1, LOOKUP, 3, 0, 0, 10'h000, 10'h000, 0, 0, 4'b0010);

        // Reset during RMW on inst0: no write, no response, sweep restarts at idx 0.
        req_valid[0] = 1'b1;
        req_op[0]    = TOUCH;
        req_idx[0]   = 4'd5;
        req_way[0]   = 2'd1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        greset[0]    = 1'b1;
        @(posedge clk);
        #1;
        greset[0] = 1'b0;
        wait_init(0);
        issue(0, LOOKUP, 5, 0, 0, 10'h000, 10'h000, 0, 0, 4'b0000);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_q.size() != 0) begin
            failures++;
            $display("FAIL rsp_queue_drain: pending=%0d required 0", rsp_q.size());
        end
        checks++;
        if (wr_q.size() != 0) begin
            failures++;
            $display("FAIL wr_queue_drain: pending=%0d required 0", wr_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
